// File: rtl/mmu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mmu_arbiter_pkg
//   Shared types for the MMU memory arbiter.
//   - mmu_state_e : arbiter FSM state (IDLE / READ / WRITE)
//   - mmu_owner_e : which cache side owns the current transfer
//   - rr_pick     : round-robin owner selection between inst and data sides
// ---------------------------------------------------------------------------
package mmu_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } mmu_state_e;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } mmu_owner_e;

    // On a conflict the side that was not granted last wins; otherwise the
    // only active side wins. With no request the result is don't-care.
    function automatic mmu_owner_e rr_pick(input logic       inst_v,
                                           input logic       data_v,
                                           input mmu_owner_e last);
        if (inst_v && data_v)
            return (last == OWNER_INST) ? OWNER_DATA : OWNER_INST;
        else if (data_v)
            return OWNER_DATA;
        else
            return OWNER_INST;
    endfunction

endpackage

// File: rtl/mmu_arbiter.sv
// ---------------------------------------------------------------------------
// mmu_arbiter
//   Arbitrates instruction-cache line fills and data-cache fills/write-backs
//   onto a narrow memory bus. A whole line is moved as BEATS bus beats, each
//   beat completing on mem_ack. The owner's done output pulses for one cycle
//   after the last beat; read lines are then held on inst_line / data_rline.
//
// Ports
//   clk, reset_n        : clock, asynchronous active-low reset
//   inst_read_req       : icache fill request
//   inst_addr           : icache fill byte address
//   inst_line           : last line filled for the icache
//   inst_done           : one-cycle icache completion pulse
//   data_read_req       : dcache fill request
//   data_write_req      : dcache write-back request (wins over read)
//   data_addr           : dcache byte address
//   data_wline          : dcache write-back line
//   data_rline          : last line filled for the dcache
//   data_done           : one-cycle dcache completion pulse
//   mem_addr            : beat byte address
//   mem_rd, mem_wr      : beat read / write strobes
//   mem_wdata           : write beat data
//   mem_rdata           : read beat data (valid with mem_ack)
//   mem_ack             : beat accepted / read data valid
//   state               : current FSM state
// ---------------------------------------------------------------------------
module mmu_arbiter
    import mmu_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256,
    parameter int BUS_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  inst_read_req,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    output logic [LINE_WIDTH-1:0] inst_line,
    output logic                  inst_done,

    input  logic                  data_read_req,
    input  logic                  data_write_req,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [LINE_WIDTH-1:0] data_wline,
    output logic [LINE_WIDTH-1:0] data_rline,
    output logic                  data_done,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [BUS_WIDTH-1:0]  mem_wdata,
    input  logic [BUS_WIDTH-1:0]  mem_rdata,
    input  logic                  mem_ack,
    output mmu_state_e            state
);

    localparam int BEATS   = LINE_WIDTH / BUS_WIDTH;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W   = $clog2(LINE_WIDTH / 8);
    localparam int BYTE_SH = $clog2(BUS_WIDTH / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    mmu_state_e            r_state;
    mmu_state_e            w_state_nxt;
    mmu_owner_e            r_owner;
    mmu_owner_e            r_last;
    mmu_owner_e            w_grant_owner;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] w_beat_addr;
    logic [BEAT_W-1:0]     r_beat;
    logic [LINE_WIDTH-1:0] r_wline;
    logic [LINE_WIDTH-1:0] r_rbuf;
    logic [LINE_WIDTH-1:0] w_rbuf_upd;
    logic [LINE_WIDTH-1:0] r_inst_line;
    logic [LINE_WIDTH-1:0] r_data_line;
    logic                  r_inst_done;
    logic                  r_data_done;
    logic                  w_inst_req;
    logic                  w_data_req;
    logic                  w_grant;
    logic                  w_grant_wr;
    logic                  w_last_ack;

    function automatic logic [ADDR_WIDTH-1:0] line_base(input logic [ADDR_WIDTH-1:0] a);
        return {a[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    endfunction

    // A side whose done is high this cycle is still showing the request it
    // was just served for, so it is masked out of arbitration.
    assign w_inst_req    = inst_read_req & ~r_inst_done;
    assign w_data_req    = (data_read_req | data_write_req) & ~r_data_done;
    assign w_grant_owner = rr_pick(w_inst_req, w_data_req, r_last);
    assign w_grant       = (r_state == IDLE) & (w_inst_req | w_data_req);
    assign w_grant_wr    = (w_grant_owner == OWNER_DATA) & data_write_req;
    assign w_last_ack    = (r_state != IDLE) & mem_ack & (r_beat == LAST_BEAT);
    assign w_beat_addr   = r_base + (ADDR_WIDTH'(r_beat) << BYTE_SH);

    // Read buffer with the beat currently on the bus merged in, so the final
    // beat lands in the delivered line on the same edge.
    always_comb begin
        w_rbuf_upd = r_rbuf;
        w_rbuf_upd[r_beat*BUS_WIDTH +: BUS_WIDTH] = mem_rdata;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant)
                    w_state_nxt = w_grant_wr ? WRITE : READ;
            end
            READ, WRITE: begin
                if (w_last_ack)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs: bus strobes, address and write data
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            READ: begin
                mem_rd   = 1'b1;
                mem_addr = w_beat_addr;
            end
            WRITE: begin
                mem_wr    = 1'b1;
                mem_addr  = w_beat_addr;
                mem_wdata = r_wline[r_beat*BUS_WIDTH +: BUS_WIDTH];
            end
            default: ;
        endcase
    end

    // Grant capture, beat counter, line registers and done pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner     <= OWNER_INST;
            r_last      <= OWNER_INST;
            r_base      <= '0;
            r_beat      <= '0;
            r_wline     <= '0;
            r_rbuf      <= '0;
            r_inst_line <= '0;
            r_data_line <= '0;
            r_inst_done <= 1'b0;
            r_data_done <= 1'b0;
        end else begin
            r_inst_done <= 1'b0;
            r_data_done <= 1'b0;
            if (w_grant) begin
                r_owner <= w_grant_owner;
                r_last  <= w_grant_owner;
                r_base  <= line_base((w_grant_owner == OWNER_INST) ? inst_addr : data_addr);
                r_beat  <= '0;
                if (w_grant_wr)
                    r_wline <= data_wline;
            end else if ((r_state != IDLE) && mem_ack) begin
                if (r_state == READ)
                    r_rbuf <= w_rbuf_upd;
                if (w_last_ack) begin
                    r_beat <= '0;
                    if (r_owner == OWNER_INST)
                        r_inst_done <= 1'b1;
                    else
                        r_data_done <= 1'b1;
                    if (r_state == READ) begin
                        if (r_owner == OWNER_INST)
                            r_inst_line <= w_rbuf_upd;
                        else
                            r_data_line <= w_rbuf_upd;
                    end
                end else begin
                    r_beat <= r_beat + 1'b1;
                end
            end
        end
    end

    assign inst_line  = r_inst_line;
    assign data_rline = r_data_line;
    assign inst_done  = r_inst_done;
    assign data_done  = r_data_done;
    assign state      = r_state;

endmodule

// File: tb/tb_mmu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mmu_arbiter
//   Self-checking bench for mmu_arbiter. A transaction-level model predicts
//   the order of granted transfers (round-robin on conflicts), the beat
//   addresses and write data on the bus, the one-cycle done pulses and the
//   lines returned from a simple address-hashed memory.
// ---------------------------------------------------------------------------
module tb_mmu_arbiter;
    import mmu_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int LW = 256;
    localparam int BW = 32;
    localparam int NB = LW / BW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          inst_read_req = 1'b0;
    logic [AW-1:0] inst_addr = '0;
    logic [LW-1:0] inst_line;
    logic          inst_done;
    logic          data_read_req = 1'b0;
    logic          data_write_req = 1'b0;
    logic [AW-1:0] data_addr = '0;
    logic [LW-1:0] data_wline = '0;
    logic [LW-1:0] data_rline;
    logic          data_done;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [BW-1:0] mem_wdata;
    logic [BW-1:0] mem_rdata;
    logic          mem_ack = 1'b0;
    mmu_state_e    state;

    mmu_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .BUS_WIDTH(BW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .inst_read_req  (inst_read_req),
        .inst_addr      (inst_addr),
        .inst_line      (inst_line),
        .inst_done      (inst_done),
        .data_read_req  (data_read_req),
        .data_write_req (data_write_req),
        .data_addr      (data_addr),
        .data_wline     (data_wline),
        .data_rline     (data_rline),
        .data_done      (data_done),
        .mem_addr       (mem_addr),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .state          (state)
    );

    always #5 clk = ~clk;

    // Memory contents are a pure function of the byte address.
    bit rd_hash = 1'b0;

    function automatic logic [BW-1:0] mem_fn(input logic [AW-1:0] a, input bit h);
        if (h)
            return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
        return 32'hA0 + {29'd0, a[4:2]};
    endfunction

    assign mem_rdata = mem_fn(mem_addr, rd_hash);

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] base, input bit h);
        logic [LW-1:0] l;
        for (int k = 0; k < NB; k++)
            l[k*BW +: BW] = mem_fn(base + 32'(4 * k), h);
        return l;
    endfunction

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model state
    bit            rr_data_last = 1'b0;
    logic [LW-1:0] exp_inst_line = '0;
    logic [LW-1:0] exp_data_line = '0;

    typedef struct {
        bit            is_data;
        bit            is_wr;
        logic [AW-1:0] base;
        logic [LW-1:0] wline;
    } xfer_t;

    task automatic drop_req(input bit is_data);
        if (is_data) begin
            data_read_req  = 1'b0;
            data_write_req = 1'b0;
        end else begin
            inst_read_req = 1'b0;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  {mem_rd, mem_wr}, 0);
        chk({tag, "_dones"}, {inst_done, data_done}, 0);
        chk({tag, "_state"}, state, IDLE);
    endtask

    // Raise requests together while the arbiter is idle, then follow every
    // resulting transfer cycle by cycle. ack_mode: 0 always ack, 1 random
    // ack, 2 three-cycle stall on beat 4.
    task automatic run_round(input bit want_i, input bit d_rd, input bit d_wr,
                             input logic [AW-1:0] a_i, input logic [AW-1:0] a_d,
                             input logic [LW-1:0] wl, input int ack_mode,
                             input bit drop_early, input bit scramble);
        xfer_t q[$];
        xfer_t x_i, x_d, cur;
        int    beat, stall, bst, pend;
        bit    ack;
        x_i.is_data = 1'b0; x_i.is_wr = 1'b0; x_i.base = a_i & ~32'h1F; x_i.wline = '0;
        x_d.is_data = 1'b1; x_d.is_wr = d_wr; x_d.base = a_d & ~32'h1F; x_d.wline = wl;
        if (want_i && (d_rd || d_wr)) begin
            if (rr_data_last) begin q.push_back(x_i); q.push_back(x_d); end
            else              begin q.push_back(x_d); q.push_back(x_i); end
        end else if (want_i) begin
            q.push_back(x_i);
        end else begin
            q.push_back(x_d);
        end
        inst_read_req  = want_i;
        inst_addr      = a_i;
        data_read_req  = d_rd;
        data_write_req = d_wr;
        data_addr      = a_d;
        data_wline     = wl;
        pend = -1;
        while (q.size() > 0) begin
            cur = q.pop_front();
            rr_data_last = cur.is_data;
            beat = 0; stall = 0; bst = 0;
            while (beat < NB) begin
                @(negedge clk);
                chk("state",    state, cur.is_wr ? WRITE : READ);
                chk("mem_rd",   mem_rd, !cur.is_wr);
                chk("mem_wr",   mem_wr, cur.is_wr);
                chk("mem_addr", mem_addr, cur.base + 32'(4 * beat));
                if (cur.is_wr)
                    chk("mem_wdata", mem_wdata, cur.wline[beat*BW +: BW]);
                chk("dones_busy", {inst_done, data_done}, 0);
                if (pend >= 0) begin
                    drop_req(pend != 0);
                    pend = -1;
                end
                case (ack_mode)
                    0:       ack = 1'b1;
                    1:       ack = (bst >= 3) || ($urandom_range(0, 3) != 0);
                    default: ack = !(beat == 4 && stall < 3);
                endcase
                mem_ack = ack;
                if (ack) begin
                    beat++;
                    bst = 0;
                    if (beat == 1) begin
                        if (drop_early)
                            drop_req(cur.is_data);
                        if (scramble) begin
                            if (cur.is_data) begin
                                data_addr  = $urandom;
                                data_wline = ~data_wline;
                            end else begin
                                inst_addr = $urandom;
                            end
                        end
                    end
                end else begin
                    stall++;
                    bst++;
                end
            end
            @(negedge clk);
            mem_ack = 1'b0;
            if (!cur.is_wr) begin
                if (cur.is_data) exp_data_line = line_of(cur.base, rd_hash);
                else             exp_inst_line = line_of(cur.base, rd_hash);
            end
            chk("inst_done",  inst_done, !cur.is_data);
            chk("data_done",  data_done, cur.is_data);
            chk("done_busy",  {mem_rd, mem_wr}, 0);
            chk("done_state", state, IDLE);
            chk("inst_line",  inst_line, exp_inst_line);
            chk("data_rline", data_rline, exp_data_line);
            // The served requester keeps its request up through the done
            // cycle and only drops it afterwards.
            pend = cur.is_data;
        end
        @(negedge clk);
        chk_idle("trail");
        if (pend >= 0)
            drop_req(pend != 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [LW-1:0] wl;
        repeat (2) @(negedge clk);

        // Reset values
        chk_idle("rst");
        chk("rst_addr",  mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_iline", inst_line, 0);
        chk("rst_dline", data_rline, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Inst fill from an unaligned address, memory returns 0xA0 + beat
        rd_hash = 1'b0;
        run_round(1'b1, 1'b0, 1'b0, 32'h0000_1004, 32'h0, '0, 0, 1'b0, 1'b0);

        // Data write-back with beat k = 0x11111111 * k
        for (int k = 0; k < NB; k++) wl[k*BW +: BW] = 32'h1111_1111 * k;
        run_round(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_2000, wl, 0, 1'b0, 1'b0);

        // Read and write both requested on the data side is a write
        rd_hash = 1'b1;
        for (int k = 0; k < NB; k++) wl[k*BW +: BW] = $urandom;
        run_round(1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_2400, wl, 0, 1'b0, 1'b0);

        // Three-cycle ack stall on beat 4
        run_round(1'b1, 1'b0, 1'b0, 32'h0000_5010, 32'h0, '0, 2, 1'b0, 1'b0);

        // Reset asserted during beat 5 of an inst fill
        inst_read_req = 1'b1;
        inst_addr     = 32'h0000_6008;
        mem_ack       = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rr_addr", mem_addr, 32'h0000_6000 + 32'(4 * k));
            chk("rr_rd",   mem_rd, 1);
        end
        reset_n = 1'b0;
        #1;
        chk("rr_rd_async",   mem_rd, 0);
        chk("rr_state",      state, IDLE);
        chk("rr_addr_async", mem_addr, 0);
        inst_read_req = 1'b0;
        mem_ack       = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk_idle("rr_hold");
        end
        reset_n       = 1'b1;
        rr_data_last  = 1'b0;
        exp_inst_line = '0;
        exp_data_line = '0;
        @(negedge clk);
        chk("rr_iline", inst_line, 0);
        chk("rr_dline", data_rline, 0);

        // Simultaneous reads after reset: data first, then inst
        run_round(1'b1, 1'b1, 1'b0, 32'h0000_3000, 32'h0000_4000, '0, 0, 1'b0, 1'b0);
        // Lone data read, then another conflict which inst must win
        run_round(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_4100, '0, 1, 1'b0, 1'b0);
        run_round(1'b1, 1'b1, 1'b0, 32'h0000_3100, 32'h0000_4200, '0, 1, 1'b0, 1'b0);

        // Randomized traffic
        for (int r = 0; r < 40; r++) begin
            bit wi;
            int dk;
            wi = 1'($urandom_range(0, 1));
            dk = int'($urandom_range(0, 3));
            if (!wi && dk == 0) wi = 1'b1;
            for (int k = 0; k < NB; k++) wl[k*BW +: BW] = $urandom;
            run_round(wi, dk[0], dk[1], $urandom, $urandom, wl,
                      int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
